// File: rtl/ex_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module ex_muldiv (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  count_reg;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] a_reg;
  logic [31:0] abs_a_reg;
  logic [31:0] abs_b_reg;
  logic [63:0] acc_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign abs_a     = (is_signed & a[31]) ? (32'd0 - a) : a;
  assign abs_b     = (is_signed & b[31]) ? (32'd0 - b) : b;

  // Multiply: add multiplicand into the top half when the current multiplier bit is set.
  assign mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, (abs_b_reg[0] ? abs_a_reg : 32'd0)};
  // Divide: acc holds {remainder, dividend/quotient}; trial-subtract the divisor.
  assign div_trial = acc_reg[63:31] - {1'b0, abs_b_reg};

  assign prod_fix  = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
  assign quo_fix   = neg_q_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
  assign rem_fix   = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];

  assign busy  = (state_reg != IDLE);
  assign stall = busy & (start | mfhi | mflo | mthi | mtlo);
  assign hi    = hi_reg;
  assign lo    = lo_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = op[1] ? DIV : MUL;
      MUL:     if (count_reg == 6'd31) state_next = FIX;
      DIV:     if (count_reg == 6'd31) state_next = FIX;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_reg  <= 6'd0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      a_reg      <= 32'd0;
      abs_a_reg  <= 32'd0;
      abs_b_reg  <= 32'd0;
      acc_reg    <= 64'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mthi) hi_reg <= a;
          if (mtlo) lo_reg <= a;
          if (start) begin
            count_reg  <= 6'd0;
            is_div_reg <= op[1];
            neg_q_reg  <= is_signed & (a[31] ^ b[31]);
            neg_r_reg  <= is_signed & a[31];
            a_reg      <= a;
            abs_a_reg  <= abs_a;
            abs_b_reg  <= abs_b;
            acc_reg    <= op[1] ? {32'd0, abs_a} : 64'd0;
          end
        end
        MUL: begin
          acc_reg   <= {mul_sum, acc_reg[31:1]};
          abs_b_reg <= {1'b0, abs_b_reg[31:1]};
          count_reg <= count_reg + 6'd1;
        end
        DIV: begin
          if (!div_trial[32]) acc_reg <= {div_trial[31:0], acc_reg[30:0], 1'b1};
          else                acc_reg <= {acc_reg[62:0], 1'b0};
          count_reg <= count_reg + 6'd1;
        end
        default: begin
          if (!is_div_reg) begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end else if (abs_b_reg == 32'd0) begin
            // Divide by zero: HI keeps the original dividend, LO saturates.
            hi_reg <= a_reg;
            lo_reg <= 32'hFFFF_FFFF;
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a reference model fills a scoreboard at launch,
// results are popped and compared when busy drops.
module tb_ex_muldiv;

  logic        clk, clr, start, mfhi, mflo, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, stall;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [63:0] prev;
  int          c;

  ex_muldiv dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    int                 ix, iy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ix = x;
    iy = y;
    case (o)
      2'b00: return sx * sy;
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ix % iy), 32'(ix / iy)};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
      prev = e;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(o, x, y));
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'd33);
    check_result(tag);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    prev = 64'd0;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    tick(); tick();
    clr = 1'b0;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0);
    check("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // Stall: MFLO waits behind a DIVU; an MTHI presented mid-op is ignored.
    op = 2'b11; a = 32'd10; b = 32'd3; start = 1'b1;
    sb.push_back(model(2'b11, 32'd10, 32'd3));
    tick();
    start = 1'b0; mflo = 1'b1;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      check("stall_busy", {63'd0, stall}, 64'd1);
      check("hold_hi", {32'd0, hi}, {32'd0, prev[63:32]});
      check("hold_lo", {32'd0, lo}, {32'd0, prev[31:0]});
      if (c == 5) begin mthi = 1'b1; a = 32'hDEAD_BEEF; end
      else mthi = 1'b0;
      tick();
      c++;
    end
    mthi = 1'b0;
    check("stall_latency", 64'(c), 64'd33);
    check("stall_release", {63'd0, stall}, 64'd0);
    check_result("stall_divu");
    mflo = 1'b0;

    // Back-to-back: start held through the op is taken on the edge after E33.
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    sb.push_back(model(2'b01, 32'd3, 32'd4));
    tick();
    a = 32'd6; b = 32'd7;
    wait_done(c);
    check("b2b_first_latency", 64'(c), 64'd33);
    check("b2b_no_stall", {63'd0, stall}, 64'd0);
    check_result("b2b_first");
    sb.push_back(model(2'b01, 32'd6, 32'd7));
    tick();
    start = 1'b0;
    check("b2b_accept", {63'd0, busy}, 64'd1);
    wait_done(c);
    check("b2b_second_latency", 64'(c), 64'd33);
    check_result("b2b_second");

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd13;
      run_op($sformatf("rand%0d_op%0d", i, i % 4), 2'(i % 4), ra, rb);
    end

    // Asynchronous reset in the middle of a multiply.
    mthi = 1'b1; a = 32'h0000_1234;
    tick();
    mthi = 1'b0;
    check("mthi_preload", {32'd0, hi}, 64'h1234);
    op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2 clr = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    #2 clr = 1'b0;
    prev = 64'd0;
    tick();
    run_op("multu_after_rst", 2'b01, 32'd7, 32'd9);

    // MTLO and MULTU launched in the same cycle.
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1; mtlo = 1'b1;
    sb.push_back(model(2'b01, 32'd5, 32'd5));
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_same_cycle", {32'd0, lo}, 64'd5);
    check("mtlo_start_busy", {63'd0, busy}, 64'd1);
    wait_done(c);
    check("mtlo_start_latency", 64'(c), 64'd33);
    check_result("mtlo_start");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, beside the ALU. Executes MULT, MULTU, DIV and DIVU into dedicated HI/LO registers, and services MTHI/MTLO writes. Because the operation takes 33 cycles, the unit raises a stall that freezes the IF/ID/EX front end while any instruction touching HI/LO waits. Its `hi`/`lo` outputs feed the EX result mux for MFHI/MFLO, whose result is then registered into the EX/MEM pipeline register.

## Interface

Parameters: none.

Ports:

- `clk` input 1: rising-edge clock.
- `clr` input 1: **reset is asynchronous and active-high**.
- `start` input 1: launch the operation selected by `op` with operands `a`, `b`.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input 32: rs operand (multiplicand / dividend).
- `b` input 32: rt operand (multiplier / divisor).
- `mfhi` input 1: EX instruction reads HI.
- `mflo` input 1: EX instruction reads LO.
- `mthi` input 1: write `a` into HI.
- `mtlo` input 1: write `a` into LO.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `busy` output 1: an operation is in progress.
- `stall` output 1: combinational; equals `busy & (start | mfhi | mflo | mthi | mtlo)`.

## Operation

- **States:** IDLE, MUL, DIV, FIX.
- **IDLE, `start`=1:**
  - Capture `op`.
  - For signed ops, store |a| and |b|, plus a negate-quotient/product flag (sign a XOR sign b) and a negate-remainder flag (sign a).
  - Clear the 6-bit count; go to MUL for op 0x, DIV for op 1x.
- **MUL:** radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first. After 32 iterations go to FIX.
- **DIV:** restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial-remainder subtract. After 32 iterations go to FIX.
- **FIX:**
  - Apply sign correction: two's-complement negation of the 64-bit product, or of the quotient and remainder separately.
  - Write HI/LO: for MUL, HI = product[63:32], LO = product[31:0]; for DIV, HI = remainder, LO = quotient.
  - Return to IDLE.
- **Divide by zero:** HI = `a` as captured, LO = 0xFFFFFFFF, for both DIV and DIVU. Still takes the full latency.
- **Signed overflow:** DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural result of the magnitude path).
- **MTHI/MTLO in IDLE:** write HI/LO on the next edge. If `start` is also high in the same cycle, the move still happens, and FIX later overwrites it.
- **While busy:** `start`, `mthi` and `mtlo` are ignored; the front end is stalled and re-presents them.
- **`hi`/`lo`** reflect only completed writes; intermediate state is never visible.

## Timing

- **Reset:** `clr`=1 forces, asynchronously, state = IDLE, count = 0, `hi` = 0, `lo` = 0, `busy` = 0, and all internal operand/accumulator registers = 0.
  - Reset mid-operation abandons the operation; HI/LO read 0 afterwards.
- **Launch:** edge E0 samples `start`. `busy` = 1 from after E0 through E33.
  - Iterations occur at E1..E32.
  - FIX writes HI/LO at E33; `busy` = 0 after E33.
  - Total latency is 33 cycles from the sampling edge.
- **Back-to-back:** a `start` held under stall is sampled at E33's successor edge. It is not accepted at E33 itself, because `busy` is still 1 during the cycle before E33.
- **Read after op:** MFHI/MFLO presented at any point during the op stalls. It reads the new value in the first cycle after E33, with zero extra penalty.
- **MTHI/MTLO:** single edge, no busy.
- **`stall`** is purely combinational from `busy` and the request inputs; it has no internal state.

## Test plan

- **MULTU:** `a`=0xFFFFFFFF, `b`=0xFFFFFFFF, `start` for one cycle. Required: `busy` 33 cycles, then `hi`=0xFFFFFFFE and `lo`=0x00000001.
- **MULT:** `a`=0xFFFFFFFD (−3), `b`=5. Required: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then DIV with `a`=0xFFFFFFF9 (−7), `b`=2. Required: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **Division corners:**
  - DIVU with `a`=100, `b`=0. Required: `hi`=0x00000064, `lo`=0xFFFFFFFF after 33 cycles.
  - DIV with `a`=0x80000000, `b`=0xFFFFFFFF. Required: `lo`=0x80000000, `hi`=0.
- **Stall:** start DIVU with `a`=10, `b`=3, and assert `mflo` from the next cycle.
  - Required: `stall`=1 for every cycle while `busy`.
  - Required: `stall`=0 and `lo`=3, `hi`=1 in the cycle after E33.
  - Required: a `mthi` presented while busy has no effect.
- **Reset mid-operation:**
  - Preload HI=0x1234 via `mthi`.
  - Start MULTU with `a`=7, `b`=9.
  - Pulse `clr` at cycle 10. Required: `busy`, `hi` and `lo` are 0 immediately, without waiting for a clock edge.
  - Restart MULTU with `a`=7, `b`=9. Required: `lo`=63, `hi`=0.
- **Simultaneous `start`+`mtlo` in IDLE:** `mtlo` with `a`=5, and MULTU with `a`=5, `b`=5, in the same cycle. Required: `lo`=5 after E0, then `lo`=25, `hi`=0 after E33.
